// File: rtl/hazard_ctrl_if.sv
// Decode/redirect to sequencing-control bundle for hazard_ctrl.
// master = decode/EX side, slave = hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       dec_rs;
  logic [4:0]       dec_rt;
  logic             dec_use_rs;
  logic             dec_use_rt;
  logic             dec_wr;
  logic [4:0]       dec_rd;
  logic             dec_load;
  logic [2:0]       jon_in;
  logic             pc_we;
  logic             fd_we;
  logic             fd_flush;
  logic             de_bubble;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output dec_rs, dec_rt, dec_use_rs, dec_use_rt,
    output dec_wr, dec_rd, dec_load, jon_in,
    input  pc_we, fd_we, fd_flush, de_bubble, stall_cnt
  );

  modport slave (
    input  dec_rs, dec_rt, dec_use_rs, dec_use_rt,
    input  dec_wr, dec_rd, dec_load, jon_in,
    output pc_we, fd_we, fd_flush, de_bubble, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// IF/ID stall/flush sequencer with a 3-entry in-flight scoreboard.
// Build macro HAZARD_FWD_EN: forwarding present, only load-use stalls.
module hazard_ctrl #(
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 16
) (
  input logic          clk,
  input logic          rstd,
  hazard_ctrl_if.slave bus
);

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       ld;
  } sb_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [2:0] FL_RELOAD = 3'(FLUSH_DEPTH - 1);

  state_e           state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;
  sb_t              sb_ex_q, sb_ex_d;
  sb_t              sb_mem_q, sb_mem_d;
  sb_t              sb_wb_q, sb_wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic pc_we, fd_we, fd_flush, de_bubble;
  logic redir, hazard;
  logic hit_rs, hit_rt;

  // WB writes the regfile before ID reads it, so it is tracked but never compared.
  logic unused_sb;
  assign unused_sb = ^{sb_wb_q, sb_mem_q, sb_ex_q.ld};

  assign redir = |bus.jon_in;

`ifdef HAZARD_FWD_EN
  // Only a load still in EX cannot be forwarded in time.
  assign hit_rs = sb_ex_q.vld & sb_ex_q.ld & (sb_ex_q.rd == bus.dec_rs);
  assign hit_rt = sb_ex_q.vld & sb_ex_q.ld & (sb_ex_q.rd == bus.dec_rt);
`else
  // Without forwarding any writer in EX or MEM blocks the read.
  assign hit_rs = (sb_ex_q.vld & (sb_ex_q.rd == bus.dec_rs))
                | (sb_mem_q.vld & (sb_mem_q.rd == bus.dec_rs));
  assign hit_rt = (sb_ex_q.vld & (sb_ex_q.rd == bus.dec_rt))
                | (sb_mem_q.vld & (sb_mem_q.rd == bus.dec_rt));
`endif

  assign hazard = (bus.dec_use_rs & (bus.dec_rs != 5'd0) & hit_rs)
                | (bus.dec_use_rt & (bus.dec_rt != 5'd0) & hit_rt);

  // Sequencing decision: redirect beats hazard, flush window counts down.
  always_comb begin
    pc_we     = 1'b1;
    fd_we     = 1'b1;
    fd_flush  = 1'b0;
    de_bubble = 1'b0;
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    if (!rstd) begin
      pc_we     = 1'b0;
      fd_we     = 1'b0;
      fd_flush  = 1'b1;
      de_bubble = 1'b1;
    end else begin
      case (state_q)
        FLUSH: begin
          fd_flush  = 1'b1;
          de_bubble = 1'b1;
          if (redir) begin
            fcnt_d = FL_RELOAD;
          end else if (fcnt_q <= 3'd1) begin
            fcnt_d  = 3'd0;
            state_d = RUN;
          end else begin
            fcnt_d = fcnt_q - 3'd1;
          end
        end
        default: begin
          priority case (1'b1)
            redir: begin
              fd_flush  = 1'b1;
              de_bubble = 1'b1;
              if (FLUSH_DEPTH > 1) begin
                state_d = FLUSH;
                fcnt_d  = FL_RELOAD;
              end else begin
                state_d = RUN;
              end
            end
            hazard: begin
              pc_we     = 1'b0;
              fd_we     = 1'b0;
              de_bubble = 1'b1;
              state_d   = STALL;
            end
            default: begin
              state_d = RUN;
            end
          endcase
        end
      endcase
    end
  end

  // Scoreboard shift and saturating stall counter.
  always_comb begin
    sb_wb_d     = sb_mem_q;
    sb_mem_d    = sb_ex_q;
    sb_ex_d     = '0;
    stall_cnt_d = stall_cnt_q;
    if (!de_bubble) begin
      sb_ex_d = '{vld: bus.dec_wr, rd: bus.dec_rd, ld: bus.dec_load};
    end
    if (!pc_we && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      state_q     <= RUN;
      fcnt_q      <= '0;
      sb_ex_q     <= '0;
      sb_mem_q    <= '0;
      sb_wb_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      sb_ex_q     <= sb_ex_d;
      sb_mem_q    <= sb_mem_d;
      sb_wb_q     <= sb_wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.pc_we     = pc_we;
  assign bus.fd_we     = fd_we;
  assign bus.fd_flush  = fd_flush;
  assign bus.de_bubble = de_bubble;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two instances share stimulus,
// a = FLUSH_DEPTH 2 / CNT_W 4, b = FLUSH_DEPTH 1 / CNT_W 16.
module tb_hazard_ctrl;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [3:0] GO  = 4'b1100;
  localparam logic [3:0] STL = 4'b0001;
  localparam logic [3:0] FL  = 4'b1111;
  localparam logic [3:0] RST = 4'b0011;

  logic clk;
  logic rstd;
  int   n_tests;
  int   n_fail;

  hazard_ctrl_if #(.CNT_W(4))  bus_a ();
  hazard_ctrl_if #(.CNT_W(16)) bus_b ();

  hazard_ctrl #(.FLUSH_DEPTH(2), .CNT_W(4)) u_dut_a (
    .clk  (clk),
    .rstd (rstd),
    .bus  (bus_a.slave)
  );

  hazard_ctrl #(.FLUSH_DEPTH(1), .CNT_W(16)) u_dut_b (
    .clk  (clk),
    .rstd (rstd),
    .bus  (bus_b.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] oa();
    return {bus_a.pc_we, bus_a.fd_we, bus_a.fd_flush, bus_a.de_bubble};
  endfunction

  function automatic logic [3:0] ob();
    return {bus_b.pc_we, bus_b.fd_we, bus_b.fd_flush, bus_b.de_bubble};
  endfunction

  task automatic drv(input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt, input logic wr,
                     input logic [4:0] rd, input logic ld,
                     input logic [2:0] jon);
    bus_a.dec_rs = rs; bus_b.dec_rs = rs;
    bus_a.dec_rt = rt; bus_b.dec_rt = rt;
    bus_a.dec_use_rs = urs; bus_b.dec_use_rs = urs;
    bus_a.dec_use_rt = urt; bus_b.dec_use_rt = urt;
    bus_a.dec_wr = wr; bus_b.dec_wr = wr;
    bus_a.dec_rd = rd; bus_b.dec_rd = rd;
    bus_a.dec_load = ld; bus_b.dec_load = ld;
    bus_a.jon_in = jon; bus_b.jon_in = jon;
  endtask

  task automatic nop(input logic [2:0] jon);
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, jon);
  endtask

  // settle, compare both instances, then advance one clock
  task automatic cyc(input string tag, input logic [3:0] ea,
                     input logic [3:0] eb);
    #2;
    check({tag, ".a"}, 32'(oa()), 32'(ea));
    check({tag, ".b"}, 32'(ob()), 32'(eb));
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rstd    = 1'b0;
    nop(3'b000);
    #1;
    check("rst_out.a", 32'(oa()), 32'(RST));
    check("rst_out.b", 32'(ob()), 32'(RST));
    check("rst_cnt.a", 32'(bus_a.stall_cnt), 32'd0);
    @(posedge clk);
    #1;
    rstd = 1'b1;

    // r0 and NOP never hazard
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 3'b000);
    cyc("r0_wr", GO, GO);
    drv(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 3'b000);
    cyc("r0_rd", GO, GO);
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd7, 1'b0, 3'b000);
    cyc("nop_wr", GO, GO);
    drv(5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 3'b000);
    cyc("nop_rd1", GO, GO);
    cyc("nop_rd2", GO, GO);
    nop(3'b000);
    cyc("drain0", GO, GO);
    check("cnt_t5", 32'(bus_a.stall_cnt), 32'd0);

    // ALU writer r5 then reader r5
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 3'b000);
    cyc("raw_wr", GO, GO);
    drv(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 3'b000);
    cyc("raw_c1", FWD ? GO : STL, FWD ? GO : STL);
    cyc("raw_c2", FWD ? GO : STL, FWD ? GO : STL);
    cyc("raw_c3", GO, GO);
    nop(3'b000);
    cyc("drain1", GO, GO);
    cyc("drain2", GO, GO);
    check("cnt_t2.a", 32'(bus_a.stall_cnt), FWD ? 32'd0 : 32'd2);
    check("cnt_t2.b", 32'(bus_b.stall_cnt), FWD ? 32'd0 : 32'd2);

    // load r6 then reader on rt
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd6, 1'b1, 3'b000);
    cyc("lu_wr", GO, GO);
    drv(5'd0, 5'd6, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 3'b000);
    cyc("lu_c1", STL, STL);
    cyc("lu_c2", FWD ? GO : STL, FWD ? GO : STL);
    cyc("lu_c3", GO, GO);
    nop(3'b000);
    cyc("drain3", GO, GO);
    cyc("drain4", GO, GO);
    check("cnt_t3", 32'(bus_a.stall_cnt), FWD ? 32'd1 : 32'd4);

    // redirect aborts a stall, then a second redirect reloads the window
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b1, 3'b000);
    cyc("rd_wr", GO, GO);
    drv(5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 3'b000);
    cyc("rd_stall", STL, STL);
    drv(5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 3'b010);
    cyc("rd_abort", FL, FL);
    nop(3'b001);
    cyc("rd_reload", FL, FL);
    nop(3'b000);
    cyc("rd_tail", FL, GO);
    cyc("rd_done", GO, GO);
    nop(3'b100);
    cyc("rd2_c1", FL, FL);
    nop(3'b000);
    cyc("rd2_c2", FL, GO);
    cyc("rd2_c3", GO, GO);
    check("cnt_t4", 32'(bus_a.stall_cnt), FWD ? 32'd2 : 32'd5);

    // load r5,(r5) repeated: steady hazard stream, a saturates at 15
    drv(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 3'b000);
    for (int i = 0; i < 45; i++) begin
      @(posedge clk);
    end
    #1;
    check("sat.a", 32'(bus_a.stall_cnt), 32'd15);
    check("cnt45.b", 32'(bus_b.stall_cnt), FWD ? 32'd24 : 32'd35);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
    end
    #1;
    check("sat_hold.a", 32'(bus_a.stall_cnt), 32'd15);

    // async reset in the middle of a stall
    nop(3'b000);
    cyc("drain5", GO, GO);
    cyc("drain6", GO, GO);
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 3'b000);
    cyc("mr_wr", GO, GO);
    drv(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 3'b000);
    #2;
    check("mr_stall.a", 32'(oa()), 32'(STL));
    rstd = 1'b0;
    #1;
    check("mr_rst.a", 32'(oa()), 32'(RST));
    check("mr_rst.b", 32'(ob()), 32'(RST));
    check("mr_cnt.a", 32'(bus_a.stall_cnt), 32'd0);
    check("mr_cnt.b", 32'(bus_b.stall_cnt), 32'd0);
    @(posedge clk);
    #1;
    rstd = 1'b1;
    cyc("mr_rel", GO, GO);
    check("mr_cnt2.a", 32'(bus_a.stall_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
